// File: rtl/comb_sweep_checker.sv
// Operand sweep driver and golden-model checker for the operator-demonstration block.
// Optional macro STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
module comb_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] VEC_LAST      = 16'hFFFF,
  parameter int unsigned ERR_CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [3:0]           op_a,
  output logic [3:0]           op_b,
  output logic [3:0]           op_c,
  output logic [3:0]           op_d,
  input  logic [3:0]           res_arith,
  input  logic [3:0]           res_shift,
  input  logic [3:0]           res_rel,
  input  logic [3:0]           res_eq,
  input  logic [3:0]           res_bitwise,
  input  logic [3:0]           res_red,
  input  logic [3:0]           res_logical,
  input  logic [3:0]           res_concat,
  input  logic [3:0]           res_cond,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [15:0]          first_err_vec,
  output logic [8:0]           first_err_mask
);

  localparam int unsigned WAIT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned WAIT_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q;
  logic [15:0]          vec_q;
  logic [WAIT_W-1:0]    wait_cnt_q;
  logic [3:0]           op_a_q, op_b_q, op_c_q, op_d_q;
  logic                 busy_q, done_q, pass_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [15:0]          first_vec_q;
  logic [8:0]           first_mask_q;

  // Golden results derived from the operands currently presented to the operator block
  logic [3:0]           exp_arith_c, exp_shift_c, exp_rel_c, exp_eq_c, exp_bitwise_c;
  logic [3:0]           exp_red_c, exp_logical_c, exp_concat_c, exp_cond_c;
  logic                 a_gt_b_c;
  logic [8:0]           mask_c;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 stop_c;

  always_comb begin
    a_gt_b_c      = op_a_q > op_b_q;
    exp_arith_c   = op_b_q + op_c_q;
    exp_shift_c   = op_b_q >> op_c_q;
    exp_rel_c     = {3'b000, a_gt_b_c};
    exp_eq_c      = {3'b000, op_a_q == op_d_q};
    exp_bitwise_c = op_b_q & op_c_q;
    exp_red_c     = {3'b000, |op_b_q};
    exp_logical_c = {3'b000, a_gt_b_c || (op_a_q > op_d_q)};
    exp_concat_c  = {op_c_q[1:0], op_d_q[3:2]};
    exp_cond_c    = a_gt_b_c ? op_a_q : op_b_q;

    mask_c = {res_cond    != exp_cond_c,
              res_concat  != exp_concat_c,
              res_logical != exp_logical_c,
              res_red     != exp_red_c,
              res_bitwise != exp_bitwise_c,
              res_eq      != exp_eq_c,
              res_rel     != exp_rel_c,
              res_shift   != exp_shift_c,
              res_arith   != exp_arith_c};
  end

  // Saturating error count and end-of-sweep decision for the vector under check
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((mask_c != 9'd0) && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
    stop_c = (vec_q == VEC_LAST);
`ifdef STOP_ON_ERR_EN
    if (mask_c != 9'd0) begin
      stop_c = 1'b1;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      wait_cnt_q   <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_c_q       <= '0;
      op_d_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_vec_q  <= '0;
      first_mask_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_q        <= '0;
            err_cnt_q    <= '0;
            first_vec_q  <= '0;
            first_mask_q <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          op_a_q     <= vec_q[15:12];
          op_b_q     <= vec_q[11:8];
          op_c_q     <= vec_q[7:4];
          op_d_q     <= vec_q[3:0];
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_W'(WAIT_LAST)) begin
            state_q <= S_CHECK;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        S_CHECK: begin
          err_cnt_q <= err_cnt_d;
          if ((mask_c != 9'd0) && (err_cnt_q == '0)) begin
            first_vec_q  <= vec_q;
            first_mask_q <= mask_c;
          end
          if (stop_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_q + 16'd1;
            state_q <= S_DRIVE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign op_c           = op_c_q;
  assign op_d           = op_d_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_cnt_q;
  assign first_err_vec  = first_vec_q;
  assign first_err_mask = first_mask_q;

endmodule

// File: doc/comb_sweep_checker.md
Name: comb_sweep_checker

Overview:
Initiator-side companion to the operator-demonstration combinational block. It drives the four 4-bit operands and samples the nine 4-bit result buses. It checks each result against an internal golden model and reports the error count and the first failure. The block sits beside the operator block in self-test and bring-up builds, and runs an exhaustive or truncated operand sweep on each start pulse.

Parameters:
SETTLE_CYCLES, 1, wait cycles between driving operands and sampling results; legal range is 1 or more.
VEC_LAST, 16'hFFFF, last sweep vector; lower it to shorten simulation.
ERR_CNT_W, 16, width of the saturating error counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a sweep; ignored while busy
op_a, op_b, op_c, op_d  out  4 each  registered operands to the operator block
res_arith, res_shift, res_rel, res_eq, res_bitwise, res_red, res_logical, res_concat, res_cond  in  4 each  result buses returned from the operator block
busy  out  1  sweep in progress
done  out  1  sweep finished; held until the next start
pass  out  1  valid only when done; 1 when err_count is 0
err_count  out  ERR_CNT_W  mismatching vectors; saturates at all-ones
first_err_vec  out  16  {A,B,C,D} of the first mismatching vector
first_err_mask  out  9  per-result failure flags for the first mismatch

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset at any time, including mid-sweep, immediately forces state IDLE and sets all outputs and internal registers to 0.
- Sweep vector: vec[15:0], with A=vec[15:12], B=vec[11:8], C=vec[7:4], D=vec[3:0]. The sweep runs from 0 to VEC_LAST in increments of 1.
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE or DONE, on start: vec=0, err_count=0, first_err_vec=0, first_err_mask=0, done=0, pass=0, busy=1; go to DRIVE.
- DRIVE: load op_* from vec, visible from the next cycle; clear the wait counter; go to WAIT.
- WAIT: hold for exactly SETTLE_CYCLES cycles, then go to CHECK.
- CHECK: sample res_* and compare against the golden model computed from the op_* registers. Build the 9-bit mismatch mask. Bit order: 0 arith, 1 shift, 2 rel, 3 eq, 4 bitwise, 5 red, 6 logical, 7 concat, 8 cond.
- On a nonzero mask: increment err_count, saturating. If err_count was 0, capture first_err_vec=vec and first_err_mask=mask.
- Leaving CHECK: if vec==VEC_LAST, go to DONE. Otherwise increment vec and go to DRIVE.
- DONE: busy=0, done=1, pass=(err_count==0). op_* keep the last vector. Stay in DONE until start.
- Per-vector latency is SETTLE_CYCLES+2 cycles. From the start pulse to done high takes (VEC_LAST+1)*(SETTLE_CYCLES+2)+1 cycles.
- Golden model, all results 4 bits, all operators unsigned:
  - arith = (B+C) mod 16
  - shift = B>>C, logical; C>=4 gives 0
  - rel = {3'b0, A>B}
  - eq = {3'b0, A==D}
  - bitwise = B&C
  - red = {3'b0, |B}
  - logical = {3'b0, (A>B)||(A>D)}
  - concat = {C[1:0], D[3:2]}
  - cond = (A>B) ? A : B
- A start pulse in DRIVE, WAIT or CHECK is ignored and has no side effects.
- The vec increment never wraps past VEC_LAST.

Optional Feature:
Macro STOP_ON_ERR_EN.
- Defined: a nonzero mask in CHECK goes directly to DONE after the first-error capture. err_count is then 1, pass is 0, vec is not incremented, and op_* hold the failing vector.
- Undefined: the sweep always completes to VEC_LAST regardless of mismatches.

Test Plan:
1. Golden operator block attached, defaults, one start pulse -> done rises 196609 cycles after start; err_count=0, pass=1, first_err_mask=0.
2. res_arith bit0 inverted only when ops=16'h1234 -> err_count=1, first_err_vec=16'h1234, first_err_mask=9'h001, pass=0.
3. res_rel bit3 stuck at 1, VEC_LAST=16'h00FF -> err_count=256, first_err_vec=16'h0000, first_err_mask=9'h004.
4. STOP_ON_ERR_EN defined, res_cond inverted at ops=16'h0042 -> done at that vector's CHECK+1 cycle; op_* read 0,0,4,2; err_count=1; first_err_mask=9'h100.
5. Start pulse while busy -> no restart, vec continues; rst_n low at vec=16'h0100 -> all outputs 0 without a clock edge; after release, start restarts the sweep from vec 0.
6. ERR_CNT_W=4, all res_* inverted, VEC_LAST=16'h001F -> err_count saturates at 15; first_err_vec=0, first_err_mask=9'h1FF.
